// File: rtl/line_motion.sv
// line_motion: game FSM, head kinematics, camera scroll, song progress and hint flags
module line_motion #(
  parameter int STEP        = 2,
  parameter int TOTAL_TICKS = 3000,
  parameter int START_X     = 336,
  parameter int START_Y     = 240,
  parameter int CENTER_X    = 320,
  parameter int CENTER_Y    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn,
  input  logic        collide,
  output logic [15:0] head_x,
  output logic [15:0] head_y,
  output logic [15:0] scroll_x,
  output logic [15:0] scroll_y,
  output logic        turn,
  output logic [9:0]  progress,
  output logic        running,
  output logic        tips_display,
  output logic        tips_display_over
);
  localparam logic [15:0] SX = 16'(START_X);
  localparam logic [15:0] SY = 16'(START_Y);
  localparam logic [15:0] CX = 16'(CENTER_X);
  localparam logic [15:0] CY = 16'(CENTER_Y);
  localparam logic [15:0] ST = 16'(STEP);
  localparam logic [16:0] TT = 17'(TOTAL_TICKS);
  typedef enum logic [1:0] {IDLE, RUN, DEAD, DONE} state_t;
  state_t state, state_nx;
  logic dir, step_en, turn_en, restart, roll;
  logic [16:0] acc, acc_sum, acc_nx;
  logic [15:0] hx_nx, hy_nx;
  logic [9:0] prog_nx;
  // collide in RUN suppresses both the step and the turn
  always_comb begin
    step_en = state == RUN && tick && !collide;
    turn_en = state == RUN && btn && !collide;
    restart = (state == DEAD || state == DONE) && btn;
    acc_sum = acc + 17'd1000;
    roll    = acc_sum >= TT;
    hx_nx   = restart ? SX : (step_en && !dir) ? head_x + ST : head_x;
    hy_nx   = restart ? SY : (step_en && dir) ? head_y + ST : head_y;
    acc_nx  = restart ? '0 : !step_en ? acc : roll ? acc_sum - TT : acc_sum;
    prog_nx = restart ? '0 : (step_en && roll && progress != 10'd1000) ? progress + 10'd1 : progress;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = btn ? RUN : IDLE;
      RUN:  state_nx = collide ? DEAD : (prog_nx == 10'd1000) ? DONE : RUN;
      DEAD: state_nx = btn ? IDLE : DEAD;
      DONE: state_nx = btn ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      head_x   <= SX;
      head_y   <= SY;
      scroll_x <= SX - CX + 16'd1;
      scroll_y <= SY - CY + 16'd1;
      dir      <= 1'b0;
      acc      <= '0;
      progress <= '0;
      turn     <= 1'b0;
    end else begin
      state    <= state_nx;
      head_x   <= hx_nx;
      head_y   <= hy_nx;
      scroll_x <= hx_nx - CX + 16'd1;
      scroll_y <= hy_nx - CY + 16'd1;
      dir      <= restart ? 1'b0 : dir ^ turn_en;
      acc      <= acc_nx;
      progress <= prog_nx;
      turn     <= turn_en;
    end
  end
  always_comb begin
    running           = state == RUN;
    tips_display      = state == IDLE;
    tips_display_over = state == DEAD || state == DONE;
  end
endmodule

// File: tb/tb_line_motion.sv
// tb_line_motion: directed stimulus with a queued scoreboard checked one cycle after each edge
module tb_line_motion;
  logic clk = 0;
  always #5 clk = ~clk;
  logic tick_a = 0, btn_a = 0, col_a = 0, rst_a = 0;
  logic tick_b = 0, btn_b = 0, col_b = 0, rst_b = 0;
  logic [15:0] hx[2], hy[2], sx[2], sy[2];
  logic [9:0] prog[2];
  logic turn[2], run[2], tips[2], over[2];

  line_motion dut_a (
    .clk(clk), .reset(rst_a), .tick(tick_a), .btn(btn_a), .collide(col_a),
    .head_x(hx[0]), .head_y(hy[0]), .scroll_x(sx[0]), .scroll_y(sy[0]), .turn(turn[0]),
    .progress(prog[0]), .running(run[0]), .tips_display(tips[0]), .tips_display_over(over[0]));

  line_motion #(.TOTAL_TICKS(1000), .START_X(65534)) dut_b (
    .clk(clk), .reset(rst_b), .tick(tick_b), .btn(btn_b), .collide(col_b),
    .head_x(hx[1]), .head_y(hy[1]), .scroll_x(sx[1]), .scroll_y(sy[1]), .turn(turn[1]),
    .progress(prog[1]), .running(run[1]), .tips_display(tips[1]), .tips_display_over(over[1]));

  typedef struct {int cyc; int d; int s; logic [15:0] v; string n;} exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_pass = 0;

  function automatic logic [15:0] act(int d, int s);
    case (s)
      0: return hx[d];
      1: return hy[d];
      2: return sx[d];
      3: return sy[d];
      4: return {15'b0, turn[d]};
      5: return {6'b0, prog[d]};
      6: return {15'b0, run[d]};
      7: return {15'b0, tips[d]};
      default: return {15'b0, over[d]};
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = act(e.d, e.s);
      n_chk++;
      if (a === e.v) n_pass++;
      else $display("FAIL %s (dut %0d cycle %0d): got %0d, expected %0d", e.n, e.d, cyc, a, e.v);
    end
  end

  task automatic drv(int d, bit t, bit b, bit c, bit r);
    @(negedge clk);
    if (d == 0) begin tick_a = t; btn_a = b; col_a = c; rst_a = r; end
    else begin tick_b = t; btn_b = b; col_b = c; rst_b = r; end
  endtask

  task automatic ex(int d, int s, int v, string n);
    exp_t e;
    e.cyc = cyc + 1; e.d = d; e.s = s; e.v = 16'(v); e.n = n;
    q.push_back(e);
  endtask

  task automatic ex_flags(int d, int r, int t, int o, string n);
    ex(d, 6, r, {n, "_running"});
    ex(d, 7, t, {n, "_tips"});
    ex(d, 8, o, {n, "_over"});
  endtask

  task automatic ex_reset(int d, int x0, int sx0, string n);
    ex(d, 0, x0, {n, "_hx"}); ex(d, 1, 240, {n, "_hy"});
    ex(d, 2, sx0, {n, "_sx"}); ex(d, 3, 1, {n, "_sy"});
    ex(d, 4, 0, {n, "_turn"}); ex(d, 5, 0, {n, "_prog"});
    ex_flags(d, 0, 1, 0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    drv(0, 0, 0, 0, 1); ex_reset(0, 336, 17, "reset");
    drv(0, 1, 0, 1, 0); ex(0, 0, 336, "idle_tick_ignored"); ex_flags(0, 0, 1, 0, "idle_collide_ignored");
    drv(0, 0, 1, 0, 0); ex_flags(0, 1, 0, 0, "start"); ex(0, 4, 0, "start_no_turn");
    for (int i = 1; i <= 10; i++) begin
      drv(0, 1, 0, 0, 0); ex(0, 0, 336 + 2 * i, "run_hx"); ex(0, 4, 0, "run_no_turn");
    end
    ex(0, 2, 37, "run_sx"); ex(0, 1, 240, "run_hy"); ex(0, 5, 3, "run_prog");
    drv(0, 1, 1, 0, 0); ex(0, 0, 358, "corner_hx"); ex(0, 1, 240, "corner_hy"); ex(0, 4, 1, "corner_turn");
    for (int i = 1; i <= 3; i++) begin
      drv(0, 1, 0, 0, 0); ex(0, 1, 240 + 2 * i, "down_hy"); ex(0, 0, 358, "down_hx"); ex(0, 4, 0, "down_turn");
    end
    ex(0, 3, 7, "down_sy"); ex(0, 5, 4, "down_prog");
    drv(0, 1, 1, 1, 0); ex_flags(0, 0, 0, 1, "dead"); ex(0, 4, 0, "dead_no_turn");
    ex(0, 0, 358, "dead_hx"); ex(0, 1, 246, "dead_hy"); ex(0, 5, 4, "dead_prog");
    drv(0, 1, 0, 0, 0); ex(0, 1, 246, "dead_tick_ignored");
    drv(0, 0, 1, 0, 0); ex_reset(0, 336, 17, "restart");
    drv(0, 0, 1, 0, 0); ex_flags(0, 1, 0, 0, "start2");
    drv(0, 1, 0, 0, 0); ex(0, 0, 338, "run2_hx");
    drv(0, 1, 1, 0, 1); ex_reset(0, 336, 17, "midrun_reset");
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 1); ex_reset(1, 65534, 65215, "b_reset");
    drv(1, 0, 1, 0, 0); ex_flags(1, 1, 0, 0, "b_start");
    drv(1, 1, 0, 0, 0); ex(1, 0, 0, "wrap_hx"); ex(1, 2, 65217, "wrap_sx"); ex(1, 5, 1, "wrap_prog");
    for (int i = 2; i <= 1000; i++) begin
      drv(1, 1, 0, 0, 0); ex(1, 5, i, "prog_step");
    end
    ex_flags(1, 0, 0, 1, "done"); ex(1, 0, 1998, "done_hx");
    drv(1, 1, 0, 0, 0); ex(1, 0, 1998, "done_tick_hx"); ex(1, 5, 1000, "done_tick_prog");
    drv(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
